// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory controller
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DSIZE_DEF     = 16;
  localparam int MEM_SPACE_DEF = 8;
  localparam int BE_W_DEF      = DSIZE_DEF / 8;

  function automatic int be_width(input int dsize);
    return dsize / 8;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the MEM stage and dmem_ctrl
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int MEM_SPACE = MEM_SPACE_DEF
);
  localparam int BE_W = be_width(DSIZE);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BE_W-1:0]      req_be;
  logic [MEM_SPACE-1:0] address;
  logic [DSIZE-1:0]     data_in;
  logic [DSIZE-1:0]     data_out;
  logic                 rd_valid;
  logic                 init_done;

  modport master (
    output req_valid, req_we, req_be, address, data_in,
    input  req_ready, data_out, rd_valid, init_done
  );

  modport slave (
    input  req_valid, req_we, req_be, address, data_in,
    output req_ready, data_out, rd_valid, init_done
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port RAM, per-byte write enable, write-first registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int MEM_SPACE = MEM_SPACE_DEF
) (
  input  logic                       clk,
  input  logic                       i_en,
  input  logic                       i_we,
  input  logic [be_width(DSIZE)-1:0] i_be,
  input  logic [MEM_SPACE-1:0]       i_addr,
  input  logic [DSIZE-1:0]           i_wdata,
  output logic [DSIZE-1:0]           o_rdata
);
  localparam int BE_W  = be_width(DSIZE);
  localparam int DEPTH = 2 ** MEM_SPACE;

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [DSIZE-1:0] r_rdata;
  logic [DSIZE-1:0] w_merged;

  // Unselected bytes keep the stored value, so a read returns the word unchanged.
  always_comb begin
    w_merged = r_mem[i_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (i_we && i_be[b]) begin
        w_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= w_merged;
      end
      r_rdata <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: clear sequencer, valid/ready handshake, read-back
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int               DSIZE      = DSIZE_DEF,
  parameter int               MEM_SPACE  = MEM_SPACE_DEF,
  parameter logic [DSIZE-1:0] INIT_VALUE = '0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int                   BE_W      = be_width(DSIZE);
  localparam logic [MEM_SPACE-1:0] LAST_ADDR = '1;

  state_t               r_state;
  logic [MEM_SPACE-1:0] r_clr_addr;
  logic                 r_ready;
  logic                 r_rd_valid;
  logic                 r_init_done;
  logic                 r_have_data;

  logic                 w_accept;
  logic                 w_init;
  logic                 w_arr_en;
  logic                 w_arr_we;
  logic [BE_W-1:0]      w_arr_be;
  logic [MEM_SPACE-1:0] w_arr_addr;
  logic [DSIZE-1:0]     w_arr_wdata;
  logic [DSIZE-1:0]     w_rdata;

  assign w_accept = bus.req_valid && r_ready;
  assign w_init   = (r_state == ST_INIT);

  // The clear sequencer owns the array port until the last location is written.
  assign w_arr_en    = w_init || w_accept;
  assign w_arr_we    = w_init ? 1'b1       : bus.req_we;
  assign w_arr_be    = w_init ? '1         : bus.req_be;
  assign w_arr_addr  = w_init ? r_clr_addr : bus.address;
  assign w_arr_wdata = w_init ? INIT_VALUE : bus.data_in;

  dmem_array #(
    .DSIZE     (DSIZE),
    .MEM_SPACE (MEM_SPACE)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_be    (w_arr_be),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_clr_addr  <= '0;
      r_ready     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_init_done <= 1'b0;
      r_have_data <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rd_valid <= 1'b0;
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_rd_valid <= w_accept;
          if (w_accept) begin
            r_have_data <= 1'b1;
          end
        end
      endcase
    end
  end

  // The RAM output register has no reset; mask it until the first transfer lands.
  assign bus.data_out  = r_have_data ? w_rdata : '0;
  assign bus.req_ready = r_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a word/byte reference model
module tb_dmem_ctrl;
  localparam int          DSIZE     = 16;
  localparam int          MEM_SPACE = 4;
  localparam int          DEPTH     = 16;
  localparam logic [15:0] INIT_VAL  = 16'hA5A5;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] model [DEPTH];
  logic [15:0] last_out;

  dmem_if #(.DSIZE(DSIZE), .MEM_SPACE(MEM_SPACE)) bus ();

  dmem_ctrl #(
    .DSIZE      (DSIZE),
    .MEM_SPACE  (MEM_SPACE),
    .INIT_VALUE (INIT_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) model[a] = INIT_VAL;
  endtask

  // Reference: a word array updated byte by byte; result is the word after the access.
  task automatic model_access(input logic we, input logic [1:0] be, input int addr,
                              input logic [15:0] data, output logic [15:0] exp);
    logic [15:0] w;
    w = model[addr];
    if (we) begin
      for (int b = 0; b < 2; b++) begin
        if (be[b]) w[8*b +: 8] = data[8*b +: 8];
      end
      model[addr] = w;
    end
    exp = w;
  endtask

  task automatic drive(input logic we, input logic [1:0] be, input int addr, input logic [15:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.address   = addr[3:0];
    bus.data_in   = data;
  endtask

  task automatic go_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'bx;
    bus.req_be    = 2'bxx;
    bus.address   = 4'bxxxx;
    bus.data_in   = 16'hxxxx;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (bus.req_ready !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go_idle();
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0000", bus.data_out); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", bus.init_done); end
  endtask

  task automatic test_init();
    tick();
    drive(1'b0, 2'b00, 3, 16'h0);
    rst = 1'b0;
    model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k < DEPTH) begin
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL init_ready edge=%0d got=%b exp=0", k, bus.req_ready); end
      end else begin
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL init_ready edge=%0d got=%b exp=1", k, bus.req_ready); end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b exp=1", bus.init_done); end
      end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL init_rd_valid edge=%0d got=%b exp=0", k, bus.rd_valid); end
    end
    tick();
    go_idle();
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL init_read_valid got=%b exp=1", bus.rd_valid); end
    checks++; if (bus.data_out !== INIT_VAL) begin errors++; $display("FAIL init_read_data got=%h exp=%h", bus.data_out, INIT_VAL); end
  endtask

  task automatic test_write_read();
    logic [15:0] exp;
    drive(1'b1, 2'b11, 5, 16'h1234);
    model_access(1'b1, 2'b11, 5, 16'h1234, exp);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h1234) begin errors++; $display("FAIL wr_full got=%b/%h exp=1/1234", bus.rd_valid, bus.data_out); end
    drive(1'b0, 2'b00, 5, 16'h0);
    model_access(1'b0, 2'b00, 5, 16'h0, exp);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h1234) begin errors++; $display("FAIL rd_after_wr got=%b/%h exp=1/1234", bus.rd_valid, bus.data_out); end
    go_idle();
  endtask

  task automatic test_byte_enable();
    logic [15:0] exp;
    drive(1'b1, 2'b01, 5, 16'hFFFF);
    model_access(1'b1, 2'b01, 5, 16'hFFFF, exp);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h12FF) begin errors++; $display("FAIL be_low got=%b/%h exp=1/12ff", bus.rd_valid, bus.data_out); end
    drive(1'b1, 2'b00, 5, 16'h0000);
    model_access(1'b1, 2'b00, 5, 16'h0000, exp);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h12FF) begin errors++; $display("FAIL be_none got=%b/%h exp=1/12ff", bus.rd_valid, bus.data_out); end
    drive(1'b1, 2'b10, 5, 16'hAB00);
    model_access(1'b1, 2'b10, 5, 16'hAB00, exp);
    tick();
    checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL be_high got=%h exp=%h", bus.data_out, exp); end
    go_idle();
    last_out = exp;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [15:0] data;
    logic [1:0]  be;
    int          addr;
    int          prev_waddr;
    prev_waddr = 0;
    for (int i = 0; i < 32; i++) begin
      data = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      if (i % 2 == 0) begin
        addr       = $urandom_range(0, DEPTH - 1);
        prev_waddr = addr;
        drive(1'b1, be, addr, data);
        model_access(1'b1, be, addr, data, exp);
      end else begin
        addr = ($urandom_range(0, 1) == 1) ? prev_waddr : $urandom_range(0, DEPTH - 1);
        drive(1'b0, be, addr, data);
        model_access(1'b0, be, addr, data, exp);
      end
      tick();
      checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== exp || bus.req_ready !== 1'b1)
        begin errors++; $display("FAIL b2b i=%0d addr=%0d got=%b/%h/%b exp=1/%h/1", i, addr, bus.rd_valid, bus.data_out, bus.req_ready, exp); end
      last_out = exp;
    end
    go_idle();
  endtask

  task automatic test_idle();
    logic [15:0] exp;
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 2'b11, r + 10, 16'($urandom));
      model_access(1'b1, 2'b11, r + 10, bus.data_in, exp);
      tick();
      go_idle();
      for (int j = 0; j < 2 + r; j++) begin
        tick();
        checks++; if (bus.rd_valid !== 1'b0 || bus.data_out !== exp)
          begin errors++; $display("FAIL idle r=%0d j=%0d got=%b/%h exp=0/%h", r, j, bus.rd_valid, bus.data_out, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int          edges;
    logic [15:0] exp;
    go_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0 || bus.init_done !== 1'b0 || bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0)
      begin errors++; $display("FAIL mid_init_reset got=%b/%b/%b/%h exp=0/0/0/0000", bus.req_ready, bus.init_done, bus.rd_valid, bus.data_out); end
    tick();
    rst = 1'b0;
    model_clear();
    wait_ready(edges);
    checks++; if (edges != DEPTH) begin errors++; $display("FAIL restart_edges got=%0d exp=%0d", edges, DEPTH); end
    drive(1'b0, 2'b00, 2, 16'h0);
    model_access(1'b0, 2'b00, 2, 16'h0, exp);
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin errors++; $display("FAIL reinit_read got=%b/%h exp=1/%h", bus.rd_valid, bus.data_out, exp); end
    drive(1'b1, 2'b11, 9, 16'h1234);
    #3;
    rst = 1'b1;
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_in_write got=%b/%b exp=0/0", bus.rd_valid, bus.req_ready); end
    go_idle();
    rst = 1'b0;
    model_clear();
    wait_ready(edges);
    checks++; if (edges != DEPTH) begin errors++; $display("FAIL restart2_edges got=%0d exp=%0d", edges, DEPTH); end
    drive(1'b0, 2'b00, 9, 16'h0);
    tick();
    go_idle();
    checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== INIT_VAL) begin errors++; $display("FAIL lost_write got=%b/%h exp=1/%h", bus.rd_valid, bus.data_out, INIT_VAL); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    last_out = '0;
    test_reset();
    test_init();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
